// File: rtl/morra_cinese.sv
// Rock-paper-scissors match controller: scores rounds, tracks wins, reports match result.
// Optional repeat-winning-move lock is enabled by defining MORRA_MOVE_LOCK_EN.
module morra_cinese (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] PRIMO,
  input  logic [1:0] SECONDO,
  input  logic       INIZIO,
  output logic [1:0] MANCHE,
  output logic [1:0] PARTITA
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t     state, state_n;
  logic [4:0] max_q, max_n;
  logic [4:0] played_q, played_n;
  logic [4:0] w1_q, w1_n;
  logic [4:0] w2_q, w2_n;
  logic [1:0] manche_n, partita_n;

  logic       rep, bad, draw, p1win, p2win;
  logic [4:0] w1_v, w2_v, pl_v;
  logic       lead1, lead2, gap2;

  assign draw  = (PRIMO == SECONDO);
  assign p1win = ((PRIMO == 2'b01) & (SECONDO == 2'b11))
               | ((PRIMO == 2'b11) & (SECONDO == 2'b10))
               | ((PRIMO == 2'b10) & (SECONDO == 2'b01));
  assign p2win = ~p1win & ~draw;
  assign bad   = (PRIMO == 2'b00) | (SECONDO == 2'b00) | rep;

  // Candidate counts if this round turns out valid
  assign pl_v  = played_q + 5'd1;
  assign w1_v  = w1_q + 5'(p1win);
  assign w2_v  = w2_q + 5'(p2win);
  assign lead1 = (w1_v > w2_v);
  assign lead2 = (w2_v > w1_v);
  assign gap2  = lead1 ? ((w1_v - w2_v) >= 5'd2)
                       : ((w2_v - w1_v) >= 5'd2);

`ifdef MORRA_MOVE_LOCK_EN
  logic [1:0] lk1_q, lk1_n;
  logic [1:0] lk2_q, lk2_n;

  // A 00 lock never matches a legal move, so it acts as "unlocked"
  assign rep = (PRIMO == lk1_q) | (SECONDO == lk2_q);

  always_comb begin
    lk1_n = lk1_q;
    lk2_n = lk2_q;
    if (INIZIO) begin
      lk1_n = 2'b00;
      lk2_n = 2'b00;
    end else if (state == PLAY && !bad) begin
      lk1_n = p1win ? PRIMO : 2'b00;
      lk2_n = p2win ? SECONDO : 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk1_q <= 2'b00;
      lk2_q <= 2'b00;
    end else begin
      lk1_q <= lk1_n;
      lk2_q <= lk2_n;
    end
  end
`else
  assign rep = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    max_n     = max_q;
    played_n  = played_q;
    w1_n      = w1_q;
    w2_n      = w2_q;
    manche_n  = 2'b00;
    partita_n = 2'b00;
    if (INIZIO) begin
      max_n    = {1'b0, PRIMO, SECONDO} + 5'd4;
      played_n = 5'd0;
      w1_n     = 5'd0;
      w2_n     = 5'd0;
      state_n  = PLAY;
    end else begin
      unique case (state)
        IDLE: ;
        PLAY: begin
          if (!bad) begin
            played_n = pl_v;
            w1_n     = w1_v;
            w2_n     = w2_v;
            if (draw)       manche_n = 2'b11;
            else if (p1win) manche_n = 2'b01;
            else            manche_n = 2'b10;
            if (pl_v >= 5'd4 && gap2)
              partita_n = lead1 ? 2'b01 : 2'b10;
            else if (pl_v == max_q)
              partita_n = lead1 ? 2'b01 : (lead2 ? 2'b10 : 2'b11);
            if (partita_n != 2'b00)
              state_n = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      max_q    <= 5'd0;
      played_q <= 5'd0;
      w1_q     <= 5'd0;
      w2_q     <= 5'd0;
      MANCHE   <= 2'b00;
      PARTITA  <= 2'b00;
    end else begin
      state    <= state_n;
      max_q    <= max_n;
      played_q <= played_n;
      w1_q     <= w1_n;
      w2_q     <= w2_n;
      MANCHE   <= manche_n;
      PARTITA  <= partita_n;
    end
  end

endmodule

// File: tb/tb_morra_cinese.sv
// Self-checking bench for morra_cinese: directed rounds plus random play
// compared against an arithmetic reference model of the match rules.
module tb_morra_cinese;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] PRIMO = 2'b00;
  logic [1:0] SECONDO = 2'b00;
  logic       INIZIO = 1'b0;
  logic [1:0] MANCHE, PARTITA;

  int checks = 0;
  int errors = 0;

`ifdef MORRA_MOVE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  morra_cinese dut (
    .clk(clk),
    .rst_n(rst_n),
    .PRIMO(PRIMO),
    .SECONDO(SECONDO),
    .INIZIO(INIZIO),
    .MANCHE(MANCHE),
    .PARTITA(PARTITA)
  );

  always #5 clk = ~clk;

  int   m_max, m_pl, m_w1, m_w2, m_l1, m_l2;
  bit   m_play;
  logic [1:0] exp_m, exp_p;

  function automatic void model_reset();
    m_max = 0; m_pl = 0; m_w1 = 0; m_w2 = 0;
    m_l1 = 0; m_l2 = 0; m_play = 1'b0;
  endfunction

  function automatic void model(input int p, input int s, input bit ini);
    int d;
    exp_m = 2'b00;
    exp_p = 2'b00;
    if (ini) begin
      m_max = p * 4 + s + 4;
      m_pl = 0; m_w1 = 0; m_w2 = 0; m_l1 = 0; m_l2 = 0;
      m_play = 1'b1;
      return;
    end
    if (!m_play) return;
    if (p == 0 || s == 0) return;
    if (LOCK && ((m_l1 != 0 && p == m_l1) || (m_l2 != 0 && s == m_l2)))
      return;
    m_pl++;
    if (p == s) begin
      exp_m = 2'b11; m_l1 = 0; m_l2 = 0;
    end else if ((p - s + 3) % 3 == 1) begin
      exp_m = 2'b01; m_w1++; m_l1 = p; m_l2 = 0;
    end else begin
      exp_m = 2'b10; m_w2++; m_l2 = s; m_l1 = 0;
    end
    d = m_w1 - m_w2;
    if (m_pl >= 4 && (d >= 2 || d <= -2))
      exp_p = (d > 0) ? 2'b01 : 2'b10;
    else if (m_pl == m_max)
      exp_p = (d > 0) ? 2'b01 : ((d < 0) ? 2'b10 : 2'b11);
    if (exp_p != 2'b00) m_play = 1'b0;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs,
                       input logic [1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [1:0] p, input logic [1:0] s,
                      input logic ini, input string tag);
    PRIMO = p;
    SECONDO = s;
    INIZIO = ini;
    model(int'(p), int'(s), ini);
    @(posedge clk);
    #1;
    check({tag, "_manche"}, MANCHE, exp_m);
    check({tag, "_partita"}, PARTITA, exp_p);
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_manche", MANCHE, 2'b00);
    check("rst_partita", PARTITA, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(2'b01, 2'b11, 1'b0, "idle_after_rst");

    step(2'b10, 2'b10, 1'b1, "start14");
    step(2'b01, 2'b11, 1'b0, "rock_v_sc");
    step(2'b10, 2'b10, 1'b0, "draw");
    step(2'b11, 2'b01, 1'b0, "sc_v_rock");
    step(2'b00, 2'b10, 1'b0, "p1_invalid");
    step(2'b01, 2'b11, 1'b0, "lock_setup");
    step(2'b01, 2'b10, 1'b0, "lock_repeat");

    step(2'b00, 2'b00, 1'b1, "start4a");
    step(2'b01, 2'b11, 1'b0, "p1w_1");
    step(2'b10, 2'b01, 1'b0, "p1w_2");
    step(2'b01, 2'b11, 1'b0, "p1w_3");
    step(2'b10, 2'b01, 1'b0, "p1w_4");
    step(2'b01, 2'b11, 1'b0, "after_end1");
    step(2'b10, 2'b01, 1'b0, "after_end2");

    step(2'b00, 2'b00, 1'b1, "start4b");
    step(2'b01, 2'b11, 1'b0, "alt_1");
    step(2'b11, 2'b01, 1'b0, "alt_2");
    step(2'b11, 2'b10, 1'b0, "alt_3");
    step(2'b01, 2'b10, 1'b0, "alt_4");

    step(2'b00, 2'b00, 1'b1, "start_mid");
    step(2'b01, 2'b11, 1'b0, "mid_round");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_manche", MANCHE, 2'b00);
    check("midrst_partita", PARTITA, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(2'b01, 2'b11, 1'b0, "post_rst1");
    step(2'b10, 2'b01, 1'b0, "post_rst2");

    for (int i = 0; i < 400; i++) begin
      logic [1:0] rp, rs;
      logic ri;
      rp = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      ri = ($urandom_range(0, 9) == 0);
      step(rp, rs, ri, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
